// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: RUN -> EDIT_HOUR -> EDIT_MIN -> COMMIT, with BCD shadow registers, blink phase and inactivity timeout.
// All outputs registered; state and load change the cycle after the causing pulse. There is no backpressure: every input pulse is consumed in the cycle it arrives.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic       load,
    output logic       editing,
    output logic       blink_hour,
    output logic       blink_min
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_S);

    state_t     state_q, state_d;
    logic [7:0] hour_q, hour_d;
    logic [7:0] min_q, min_d;
    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic       load_q, load_d;
    logic       editing_q, editing_d;
    logic       blink_hour_q, blink_hour_d;
    logic       blink_min_q, blink_min_d;
    logic [8:0] cnt_inc;
    logic       in_edit;

    // Shadows only ever hold legal BCD, so the wrap test can compare against the field maximum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v >= max_v)
            return 8'h00;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign in_edit = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                cnt_d = 8'd0;
                if (mode_btn) begin
                    hour_d  = bcd_ok(cur_hour, 8'h23) ? cur_hour : 8'h00;
                    min_d   = bcd_ok(cur_min, 8'h59) ? cur_min : 8'h00;
                    state_d = EDIT_HOUR;
                end
            end
            EDIT_HOUR, EDIT_MIN: begin
                // Button activity always beats an expiring tick.
                if (mode_btn) begin
                    cnt_d   = 8'd0;
                    state_d = (state_q == EDIT_HOUR) ? EDIT_MIN : COMMIT;
                end else if (inc_btn) begin
                    cnt_d = 8'd0;
                    if (state_q == EDIT_HOUR)
                        hour_d = bcd_inc(hour_q, 8'h23);
                    else
                        min_d = bcd_inc(min_q, 8'h59);
                end else if (tick_1hz) begin
                    if (cnt_inc >= TIMEOUT_LIM) begin
                        cnt_d   = 8'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_inc[7:0];
                    end
                end
            end
            COMMIT: begin
                cnt_d   = 8'd0;
                state_d = RUN;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = RUN;
            end
        endcase

        editing_d = (state_d == EDIT_HOUR) || (state_d == EDIT_MIN);
        if (!editing_d)
            phase_d = 1'b0;
        else if (tick_1hz && in_edit)
            phase_d = ~phase_q;
        else
            phase_d = phase_q;

        load_d       = (state_d == COMMIT);
        blink_hour_d = phase_d && (state_d == EDIT_HOUR);
        blink_min_d  = phase_d && (state_d == EDIT_MIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            hour_q       <= 8'h00;
            min_q        <= 8'h00;
            cnt_q        <= 8'd0;
            phase_q      <= 1'b0;
            load_q       <= 1'b0;
            editing_q    <= 1'b0;
            blink_hour_q <= 1'b0;
            blink_min_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            load_q       <= load_d;
            editing_q    <= editing_d;
            blink_hour_q <= blink_hour_d;
            blink_min_q  <= blink_min_d;
        end
    end

    assign set_hour   = hour_q;
    assign set_min    = min_q;
    assign load       = load_q;
    assign editing    = editing_q;
    assign blink_hour = blink_hour_q;
    assign blink_min  = blink_min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: each stimulus cycle queues the expected registered outputs; a monitor pops and compares after every clock edge.
module tb_time_set_ctrl;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic       load;
        logic       editing;
        logic       bh;
        logic       bm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [7:0] cur_hour = 8'h14;
    logic [7:0] cur_min = 8'h37;
    logic [7:0] set_hour, set_min;
    logic       load, editing, blink_hour, blink_min;

    exp_t exp_q[$];
    exp_t mon_exp, mon_got;
    int   n_checks = 0;
    int   n_fail = 0;
    int   step_no = 0;

    time_set_ctrl #(.TIMEOUT_S(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .load       (load),
        .editing    (editing),
        .blink_hour (blink_hour),
        .blink_min  (blink_min)
    );

    always #5 clk = ~clk;

    // Monitor: one queued expectation per clock edge, sampled 1ns after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_got = '{set_hour, set_min, load, editing, blink_hour, blink_min};
                n_checks++;
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL cycle_%0d: got hour=%h min=%h load=%b editing=%b bh=%b bm=%b, expected hour=%h min=%h load=%b editing=%b bh=%b bm=%b",
                             n_checks, mon_got.hour, mon_got.min, mon_got.load, mon_got.editing, mon_got.bh, mon_got.bm,
                             mon_exp.hour, mon_exp.min, mon_exp.load, mon_exp.editing, mon_exp.bh, mon_exp.bm);
                end
            end
        end
    end

    task automatic step(input logic r, input logic m, input logic i, input logic t,
                        input logic [7:0] eh, input logic [7:0] em,
                        input logic el, input logic ee, input logic ebh, input logic ebm);
        exp_t e;
        @(negedge clk);
        rst      = r;
        mode_btn = m;
        inc_btn  = i;
        tick_1hz = t;
        e = '{eh, em, el, ee, ebh, ebm};
        exp_q.push_back(e);
        step_no++;
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

        // Capture 14:37, blink on hour only, timeout counter cleared by inc
        step(0, 1, 0, 0, 8'h14, 8'h37, 0, 1, 0, 0);
        step(0, 0, 0, 1, 8'h14, 8'h37, 0, 1, 1, 0);
        step(0, 0, 0, 1, 8'h14, 8'h37, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h15, 8'h37, 0, 1, 0, 0);
        step(0, 0, 0, 1, 8'h15, 8'h37, 0, 1, 1, 0);
        step(0, 0, 1, 0, 8'h16, 8'h37, 0, 1, 1, 0);
        step(0, 0, 0, 1, 8'h16, 8'h37, 0, 1, 0, 0);

        // EDIT_MIN, three silent ticks -> RUN with no load; inc in RUN ignored
        step(0, 1, 0, 0, 8'h16, 8'h37, 0, 1, 0, 0);
        step(0, 0, 0, 1, 8'h16, 8'h37, 0, 1, 0, 1);
        step(0, 0, 0, 1, 8'h16, 8'h37, 0, 1, 0, 0);
        step(0, 0, 0, 1, 8'h16, 8'h37, 0, 0, 0, 0);
        step(0, 0, 0, 0, 8'h16, 8'h37, 0, 0, 0, 0);
        step(0, 0, 1, 0, 8'h16, 8'h37, 0, 0, 0, 0);

        // Same again, inc on the third tick keeps EDIT_MIN alive, then commit
        step(0, 1, 0, 0, 8'h14, 8'h37, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h14, 8'h37, 0, 1, 0, 0);
        step(0, 0, 0, 1, 8'h14, 8'h37, 0, 1, 0, 1);
        step(0, 0, 0, 1, 8'h14, 8'h37, 0, 1, 0, 0);
        step(0, 0, 1, 1, 8'h14, 8'h38, 0, 1, 0, 1);
        step(0, 0, 0, 1, 8'h14, 8'h38, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h14, 8'h38, 1, 0, 0, 0);
        step(0, 0, 0, 0, 8'h14, 8'h38, 0, 0, 0, 0);

        // Hour wrap 22 -> 23 -> 00, minute wrap 59 -> 00
        cur_hour = 8'h22; cur_min = 8'h59;
        step(0, 1, 0, 0, 8'h22, 8'h59, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h23, 8'h59, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h00, 8'h59, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h59, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

        // 09 -> 10, then mode+inc together: mode wins, hour unchanged
        cur_hour = 8'h09; cur_min = 8'h05;
        step(0, 1, 0, 0, 8'h09, 8'h05, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h10, 8'h05, 0, 1, 0, 0);
        step(0, 1, 1, 0, 8'h10, 8'h05, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h10, 8'h05, 1, 0, 0, 0);
        step(0, 0, 0, 0, 8'h10, 8'h05, 0, 0, 0, 0);

        // Full sequence 14 -> 17, min 59 -> 00; cur_* changes after capture are ignored
        cur_hour = 8'h14; cur_min = 8'h59;
        step(0, 1, 0, 0, 8'h14, 8'h59, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h15, 8'h59, 0, 1, 0, 0);
        cur_hour = 8'h05; cur_min = 8'h12;
        step(0, 0, 1, 0, 8'h16, 8'h59, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h17, 8'h59, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h17, 8'h59, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h17, 8'h00, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h17, 8'h00, 1, 0, 0, 0);
        step(0, 0, 0, 0, 8'h17, 8'h00, 0, 0, 0, 0);

        // Illegal captures are replaced by 00
        cur_hour = 8'h3A; cur_min = 8'h4B;
        step(0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        cur_hour = 8'h24; cur_min = 8'h60;
        step(0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

        // 19 -> 20, then reset asserted inside the COMMIT cycle
        cur_hour = 8'h19; cur_min = 8'h45;
        step(0, 1, 0, 0, 8'h19, 8'h45, 0, 1, 0, 0);
        step(0, 0, 1, 0, 8'h20, 8'h45, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h20, 8'h45, 0, 1, 0, 0);
        step(0, 1, 0, 0, 8'h20, 8'h45, 1, 0, 0, 0);
        step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);

        @(negedge clk);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        tick_1hz = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
